// File: rtl/tag_skid_buffer_pkg.sv
// Shared types for the tag pipeline: skid buffer state and physical tag width.
// State encoding doubles as the occupancy count.
package pipe_pkg;
  localparam int TAG_W = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;
endpackage

// File: rtl/tag_skid_buffer_if.sv
// Valid/ready handshake bundle for both sides of the tag skid buffer.
// The buffer itself uses the slave modport; its environment uses master.
interface tag_skid_buffer_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = TAG_W
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/tag_skid_buffer_pipe_reg_en.sv
// WIDTH-bit register with async active-low reset, synchronous clear and load enable.
// Clear wins over enable so a flush always empties the slot.
module pipe_reg_en
  import pipe_pkg::*;
#(
  parameter int WIDTH = TAG_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/tag_skid_buffer.sv
// Two-entry skid buffer for physical register tags with registered in_ready,
// flush squash, occupancy export and a saturating stall-cycle counter.
module tag_skid_buffer
  import pipe_pkg::*;
#(
  parameter int WIDTH = TAG_W,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  tag_skid_buffer_if.slave   bus,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cycles
);
  skid_state_t      r_state;
  skid_state_t      w_state_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_main_en;
  logic             w_skid_en;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;
  logic [CNT_W-1:0] r_stall;

  // in_ready depends only on the state register, never on out_ready.
  assign bus.in_ready  = (r_state != FULL);
  assign bus.out_valid = (r_state != EMPTY);
  assign bus.out_data  = w_main_q;
  assign occupancy     = r_state;
  assign stall_cycles  = r_stall;

  assign w_push = bus.in_valid & bus.in_ready;
  assign w_pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_en   = 1'b0;
    w_skid_en   = 1'b0;
    w_main_d    = bus.in_data;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_state_nxt = ONE;
            w_main_en   = 1'b1;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            w_main_en = 1'b1;
          end else if (w_push) begin
            w_state_nxt = FULL;
            w_skid_en   = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          // Skid entry is older than anything upstream, so it refills main.
          if (w_pop) begin
            w_state_nxt = ONE;
            w_main_en   = 1'b1;
            w_main_d    = w_skid_q;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  pipe_reg_en #(.WIDTH(WIDTH)) u_main (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clr   (flush),
    .i_en    (w_main_en),
    .i_d     (w_main_d),
    .o_q     (w_main_q)
  );

  pipe_reg_en #(.WIDTH(WIDTH)) u_skid (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clr   (flush),
    .i_en    (w_skid_en),
    .i_d     (bus.in_data),
    .o_q     (w_skid_q)
  );

  // Flush deliberately does not touch the counter; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall <= '0;
    end else if (bus.in_valid && !bus.in_ready && (r_stall != '1)) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_tag_skid_buffer.sv
// Randomized and directed bench for tag_skid_buffer against a queue-based model.
// A second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_tag_skid_buffer;
  import pipe_pkg::*;

  localparam int W = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  occ_a, occ_b;
  logic [15:0] stall_a;
  logic [3:0]  stall_b;

  tag_skid_buffer_if #(.WIDTH(W)) bus_a ();
  tag_skid_buffer_if #(.WIDTH(W)) bus_b ();

  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.in_data   = bus_a.in_data;
  assign bus_b.out_ready = bus_a.out_ready;

  tag_skid_buffer #(.WIDTH(W), .CNT_W(16)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .bus          (bus_a),
    .occupancy    (occ_a),
    .stall_cycles (stall_a)
  );

  tag_skid_buffer #(.WIDTH(W), .CNT_W(4)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .bus          (bus_b),
    .occupancy    (occ_b),
    .stall_cycles (stall_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: FIFO contents, uncapped stall count, and whether main was last cleared.
  int q[$];
  int stall_ref = 0;
  bit data_zero = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_all();
    chk("in_ready",  32'(bus_a.in_ready),  32'(q.size() < 2));
    chk("out_valid", 32'(bus_a.out_valid), 32'(q.size() > 0));
    chk("occupancy", 32'(occ_a),           32'(q.size()));
    chk("occ_b",     32'(occ_b),           32'(q.size()));
    if (q.size() > 0) begin
      chk("out_data",   32'(bus_a.out_data), 32'(q[0]));
      chk("out_data_b", 32'(bus_b.out_data), 32'(q[0]));
    end else if (data_zero) begin
      chk("out_data_clr", 32'(bus_a.out_data), 32'd0);
    end
    chk("stall16", 32'(stall_a), 32'(sat(stall_ref, 16)));
    chk("stall4",  32'(stall_b), 32'(sat(stall_ref, 4)));
  endtask

  task automatic step(input bit v, input logic [W-1:0] d, input bit r, input bit f);
    bit full, push, pop;
    bus_a.in_valid  = v;
    bus_a.in_data   = d;
    bus_a.out_ready = r;
    flush           = f;
    @(posedge clk);
    full = (q.size() == 2);
    push = v && !full;
    pop  = (q.size() > 0) && r;
    if (v && full) stall_ref++;
    if (f) begin
      q.delete();
      data_zero = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(int'(d));
        data_zero = 1'b0;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bus_a.in_valid  = 1'b0;
    bus_a.in_data   = '0;
    bus_a.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus_a.in_ready),  32'd1);
    @(negedge clk);
    reset = 1'b1;
    check_all();

    // Streaming
    for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure fill, stall counting, then drain
    step(1'b1, 5'h0A, 1'b0, 1'b0);
    step(1'b1, 5'h0B, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 5'h0C, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous push and pop while holding one entry
    step(1'b1, 5'h03, 1'b0, 1'b0);
    step(1'b1, 5'h04, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush colliding with push and pop while full
    step(1'b1, 5'h11, 1'b0, 1'b0);
    step(1'b1, 5'h12, 1'b0, 1'b0);
    step(1'b1, 5'h13, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);

    // Counter saturation on the narrow instance, then flush must not clear it
    step(1'b1, 5'h01, 1'b0, 1'b0);
    step(1'b1, 5'h02, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 5'h05, 1'b0, 1'b0);
    chk("stall4_sat", 32'(stall_b), 32'hF);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("stall4_after_flush", 32'(stall_b), 32'hF);

    // Asynchronous reset mid-cycle while full
    step(1'b1, 5'h11, 1'b0, 1'b0);
    step(1'b1, 5'h12, 1'b0, 1'b0);
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("arst_in_ready",  32'(bus_a.in_ready),  32'd1);
    chk("arst_occ",       32'(occ_a),           32'd0);
    chk("arst_out_data",  32'(bus_a.out_data),  32'd0);
    chk("arst_stall",     32'(stall_a),         32'd0);
    q.delete();
    stall_ref = 0;
    data_zero = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    check_all();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(99) < 70, W'($urandom), $urandom_range(99) < 60,
           $urandom_range(99) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
